load_store_unit: RTL and testbench

//   Sits directly upstream of the word-only data memory and serves load/store requests from the execute stage.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory.
// Byte and halfword stores are done as read-modify-write; faulted accesses never write.
module load_store_unit #(
    parameter int MEM_WORDS    = 32,
    parameter bit CHECK_BOUNDS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_oob,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        oob_q, oob_d;

    logic        accept;
    logic        fault_mis;
    logic        fault_oob;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        fault_mis = (req_size == SZ_RSVD) ||
                    ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        fault_oob = CHECK_BOUNDS && ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    end

    // Lane placement for both the store merge and the load extract.
    always_comb begin
        lane_shift = (size_q == SZ_HALF) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00ff << lane_shift;
                lane_data = {24'h0, wdata_q[7:0]} << lane_shift;
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_ffff << lane_shift;
                lane_data = {16'h0, wdata_q[15:0]} << lane_shift;
            end
            default: begin
                lane_mask = 32'hffff_ffff;
                lane_data = wdata_q;
            end
        endcase
        merged     = (word_q & ~lane_mask) | (lane_data & lane_mask);
        rd_shifted = mem_read_data >> lane_shift;
        case (size_q)
            SZ_BYTE: load_ext = {{24{rd_shifted[7] & signed_q}}, rd_shifted[7:0]};
            SZ_HALF: load_ext = {{16{rd_shifted[15] & signed_q}}, rd_shifted[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        oob_d    = oob_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (fault_mis || fault_oob) begin
                        state_d = RESP;
                        rdata_d = '0;
                        mis_d   = fault_mis;
                        oob_d   = fault_oob;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d = mem_read_data;
                if (write_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    rdata_d = load_ext;
                    mis_d   = 1'b0;
                    oob_d   = 1'b0;
                end
            end
            WRITE: begin
                state_d = RESP;
                rdata_d = '0;
                mis_d   = 1'b0;
                oob_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            oob_q    <= oob_d;
        end
    end

    // Memory strobes decode from the async-reset state, so a reset drops them immediately.
    assign mem_memwrite    = (state_q == WRITE);
    assign mem_address     = {addr_q[31:2], 2'b00};
    assign mem_write_data  = (state_q == WRITE) ? merged : '0;
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign resp_oob        = oob_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a queue-based reference model and directed literal cases.
module tb_load_store_unit;

    localparam int MW = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_oob;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_memwrite;

    load_store_unit #(.MEM_WORDS(MW), .CHECK_BOUNDS(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_oob(resp_oob),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oob;
        logic        wr;
        int          widx;
        logic [31:0] wval;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];
    int          checks = 0, fails = 0, cyc = 0, wr_cnt = 0, exp_wr = 0;
    int          acc_cyc = 0, last_valid_cyc = -1;
    logic [31:0] got_rdata = '0, hold_rdata = '0;
    logic        got_mis = 1'b0, got_oob = 1'b0, hold_mis = 1'b0, hold_oob = 1'b0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2] % 30'(MW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-only memory with combinational read, as the unit expects.
    assign mem_read_data = mem[widx(mem_address)];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_memwrite === 1'b1) begin
            mem[widx(mem_address)] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model: decides the response and memory effect at accept time.
    task automatic model_accept(input logic w, input logic [1:0] s, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd);
        exp_t        x;
        logic [31:0] word, sh, nw;
        int          lat;
        x.mis   = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
        x.oob   = (a[31:2] >= 30'(MW));
        x.rdata = '0;
        x.wr    = 1'b0;
        x.widx  = widx(a);
        x.wval  = '0;
        word    = ref_mem[x.widx];
        if (x.mis || x.oob) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            if (s == 2'd0) begin
                sh = word >> (8 * a[1:0]);
                x.rdata = sg ? 32'($signed(sh[7:0])) : {24'h0, sh[7:0]};
            end else if (s == 2'd1) begin
                sh = word >> (16 * a[1]);
                x.rdata = sg ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
            end else begin
                x.rdata = word;
            end
        end else begin
            lat  = (s == 2'd2) ? 2 : 3;
            x.wr = 1'b1;
            nw   = word;
            if (s == 2'd2)      nw = wd;
            else if (s == 2'd0) nw[8 * a[1:0] +: 8] = wd[7:0];
            else                nw[16 * a[1] +: 16] = wd[15:0];
            x.wval = nw;
        end
        x.due = cyc + lat;
        q.push_back(x);
    endtask

    // Single compare process: every negedge, outputs must match the model.
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_flags", {30'd0, resp_misaligned, resp_oob}, 32'd0);
            hold_rdata = '0;
            hold_mis   = 1'b0;
            hold_oob   = 1'b0;
        end else begin
            chk("mem_addr_align", {30'd0, mem_address[1:0]}, 32'd0);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
                chk("resp_oob", 32'(resp_oob), 32'(e.oob));
                if (e.wr) begin
                    ref_mem[e.widx] = e.wval;
                    exp_wr++;
                end
                chk("mem_word", mem[e.widx], ref_mem[e.widx]);
                chk("write_count", 32'(wr_cnt), 32'(exp_wr));
                hold_rdata = e.rdata;
                hold_mis   = e.mis;
                hold_oob   = e.oob;
            end else begin
                chk("resp_quiet", 32'(resp_valid), 32'd0);
                chk("hold_rdata", resp_rdata, hold_rdata);
                chk("hold_flags", {30'd0, resp_misaligned, resp_oob}, {30'd0, hold_mis, hold_oob});
            end
            if (resp_valid === 1'b1) begin
                got_rdata      = resp_rdata;
                got_mis        = resp_misaligned;
                got_oob        = resp_oob;
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic send(input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clock);
        req_write = w; req_size = s; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        model_accept(w, s, sg, a, wd);
        @(posedge clock);
        #1;
        // Junk while busy must be ignored.
        req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic lit(input string name, input logic [31:0] rd, input int lat);
        wait_done();
        chk({name, "_rdata"}, got_rdata, rd);
        chk({name, "_latency"}, 32'(last_valid_cyc - acc_cyc), 32'(lat));
    endtask

    initial begin
        int w0;
        logic [31:0] a;
        reset = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h1234_5678;
        for (int i = 0; i < MW; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        req_valid = 1'b0;

        send(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        lit("sw_10", 32'h0, 2);
        chk("sw_10_model_w4", ref_mem[4], 32'hDEADBEEF);
        chk("sw_10_mem_w4", mem[4], 32'hDEADBEEF);
        send(0, 2'd2, 0, 32'h10, 32'h0);
        lit("lw_10", 32'hDEADBEEF, 2);

        send(1, 2'd0, 0, 32'h12, 32'hFFFF_FF5A);
        lit("sb_12", 32'h0, 3);
        chk("sb_12_mem_w4", mem[4], 32'hDE5ABEEF);
        send(0, 2'd0, 1, 32'h12, 32'h0);
        lit("lb_12", 32'h0000_005A, 2);
        send(0, 2'd0, 0, 32'h13, 32'h0);
        lit("lbu_13", 32'h0000_00DE, 2);
        send(0, 2'd0, 1, 32'h13, 32'h0);
        lit("lb_13", 32'hFFFF_FFDE, 2);

        send(1, 2'd2, 0, 32'h14, 32'h1122_3344);
        send(1, 2'd1, 0, 32'h16, 32'h0000_8001);
        lit("sh_16", 32'h0, 3);
        chk("sh_16_mem_w5", mem[5], 32'h8001_3344);
        send(0, 2'd1, 1, 32'h16, 32'h0);
        lit("lh_16", 32'hFFFF_8001, 2);
        send(0, 2'd1, 0, 32'h16, 32'h0);
        lit("lhu_16", 32'h0000_8001, 2);

        w0 = wr_cnt;
        send(0, 2'd1, 1, 32'h11, 32'h0);
        lit("lh_11_mis", 32'h0, 1);
        chk("lh_11_flags", {30'd0, got_mis, got_oob}, 32'd2);
        send(1, 2'd2, 0, 32'h22, 32'hCAFE_F00D);
        lit("sw_22_mis", 32'h0, 1);
        chk("sw_22_flags", {30'd0, got_mis, got_oob}, 32'd2);
        send(1, 2'd3, 0, 32'h20, 32'hCAFE_F00D);
        lit("rsvd_mis", 32'h0, 1);
        chk("rsvd_flags", {30'd0, got_mis, got_oob}, 32'd2);
        send(1, 2'd2, 0, 32'h80, 32'hCAFE_F00D);
        lit("sw_80_oob", 32'h0, 1);
        chk("sw_80_flags", {30'd0, got_mis, got_oob}, 32'd1);
        chk("fault_no_writes", 32'(wr_cnt), 32'(w0));

        // Reset during the WRITE cycle of a byte store.
        send(1, 2'd0, 0, 32'h10, 32'h0000_0077);
        @(negedge clock);
        chk("t6_in_write", 32'(mem_memwrite), 32'd1);
        #2 reset = 1'b0;
        q.delete();
        #1 chk("t6_async_drop", 32'(mem_memwrite), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        chk("t6_w4_unchanged", mem[4], 32'hDE5ABEEF);
        send(0, 2'd2, 0, 32'h10, 32'h0);
        lit("t6_lw_after", 32'hDE5ABEEF, 2);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 32'h9F));
            send(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end
        wait_done();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
